// File: rtl/skey_pkg.sv
// rtl/skey_pkg.sv - Shared constants, state encoding and PINIT lookup for the subkey expander
// Contents:
//   PI      : first 40 32-bit words of the hex fraction of pi (covers 20 entries at 64 bits)
//   S_*     : legacy numeric state codes; skey_state_e is built from them
//   pinit() : initial P-array word for a given word width and entry index
package skey_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    LOAD   = S_LOAD,
    EXPAND = S_EXPAND,
    DONE   = S_DONE
  } skey_state_e;

  localparam logic [31:0] PI [40] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC,
    32'h2FFD72DB, 32'hD01ADFB7, 32'hB8E1AFED, 32'h6A267E96,
    32'hBA7C9045, 32'hF12C7F99, 32'h24A19947, 32'hB3916CF7,
    32'h0801F2E2, 32'h858EFC16, 32'h636920D8, 32'h71574E69,
    32'hA458FEA3, 32'hF4933D7E, 32'h0D95748F, 32'h728EB658,
    32'h718BCD58, 32'h82154AEE, 32'h7B54A41D, 32'hC25A59B5
  };

  // Result is right-aligned; 32-bit callers take the low half.
  function automatic logic [63:0] pinit(input int word_w, input int idx);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = 6'(2 * idx);
    lo = 6'(2 * idx + 1);
    if (word_w == 64) return {PI[hi], PI[lo]};
    lo = 6'(idx);
    return {32'h0, PI[lo]};
  endfunction

endpackage

// File: rtl/skey_regfile.sv
// rtl/skey_regfile.sv - P-array storage with one write port and a registered, order-mapped read port
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (clears storage and rd_data)
//   clr          : synchronous clear of all entries
//   we/waddr/wdata : write port
//   rev          : 1 = read entry NUM_P-1-rd_idx instead of rd_idx
//   rd_idx       : read index; indices >= NUM_P read as 0
//   rd_data      : registered read data, one cycle after rd_idx
module skey_regfile
  import skey_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NUM_P  = 20,
  parameter int IW     = $clog2(NUM_P)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rev,
  input  logic [IW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [NUM_P];
  logic [IW-1:0]     raddr;
  logic              rd_oob;

  always_comb begin
    rd_oob = (rd_idx >= IW'(NUM_P));
    raddr  = rev ? (IW'(NUM_P - 1) - rd_idx) : rd_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_P; k++) mem[k] <= '0;
      rd_data <= '0;
    end else begin
      if (clr) begin
        for (int k = 0; k < NUM_P; k++) mem[k] <= '0;
      end else if (we) begin
        mem[waddr] <= wdata;
      end
      rd_data <= rd_oob ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/skey_expand_p.sv
// rtl/skey_expand_p.sv - Serial-key Blowfish-style P-array expander with indexed subkey readout
// Optional feature macro: SKEY_ZEROIZE_EN (adds the zeroize input)
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start, encrypt : begin key load (IDLE/DONE only); mode latched on start
//   key_in/key_valid/key_last/key_ready : key word stream handshake
//   busy           : LOAD or EXPAND in progress
//   skey_ready     : P-array valid
//   rd_idx/rd_data : subkey read, registered, order reversed when decrypting
//   zeroize        : (SKEY_ZEROIZE_EN) wipe key buffer and P-array, return to IDLE
module skey_expand_p
  import skey_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int NUM_P         = 20,
  parameter int MAX_KEY_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     encrypt,
  input  logic [WORD_W-1:0]        key_in,
  input  logic                     key_valid,
  input  logic                     key_last,
  output logic                     key_ready,
  output logic                     busy,
  output logic                     skey_ready,
  input  logic [$clog2(NUM_P)-1:0] rd_idx,
  output logic [WORD_W-1:0]        rd_data
`ifdef SKEY_ZEROIZE_EN
  ,
  input  logic                     zeroize
`endif
);

  localparam int IW = $clog2(NUM_P);
  localparam int KW = (MAX_KEY_WORDS > 1) ? $clog2(MAX_KEY_WORDS) : 1;
  localparam int LW = $clog2(MAX_KEY_WORDS + 1);

  skey_state_e       state;
  logic [WORD_W-1:0] key_buf [MAX_KEY_WORDS];
  logic [KW-1:0]     cnt;
  logic [LW-1:0]     key_len;
  logic [KW-1:0]     key_ptr;
  logic [IW-1:0]     exp_i;
  logic              enc_mode;
  logic              zero_req;
  logic              ptr_wrap;
  logic [WORD_W-1:0] wdata;

`ifdef SKEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign key_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == EXPAND);

  // key_ptr tracks i mod key_len without a divider.
  assign ptr_wrap = (LW'(key_ptr) == key_len - LW'(1));
  assign wdata    = WORD_W'(pinit(WORD_W, int'(exp_i))) ^ key_buf[key_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      key_len    <= '0;
      key_ptr    <= '0;
      exp_i      <= '0;
      enc_mode   <= 1'b0;
      skey_ready <= 1'b0;
      for (int k = 0; k < MAX_KEY_WORDS; k++) key_buf[k] <= '0;
    end else if (zero_req) begin
      state      <= IDLE;
      cnt        <= '0;
      skey_ready <= 1'b0;
      for (int k = 0; k < MAX_KEY_WORDS; k++) key_buf[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            enc_mode   <= encrypt;
            skey_ready <= 1'b0;
            cnt        <= '0;
            state      <= LOAD;
          end else if (state == DONE) begin
            // Set one cycle after entering DONE so the last write has landed.
            skey_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (key_valid) begin
            key_buf[cnt] <= key_in;
            cnt          <= cnt + KW'(1);
            if (key_last || (cnt == KW'(MAX_KEY_WORDS - 1))) begin
              key_len <= LW'(cnt) + LW'(1);
              key_ptr <= '0;
              exp_i   <= '0;
              state   <= EXPAND;
            end
          end
        end
        EXPAND: begin
          exp_i   <= exp_i + IW'(1);
          key_ptr <= ptr_wrap ? '0 : key_ptr + KW'(1);
          if (exp_i == IW'(NUM_P - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skey_regfile #(
    .WORD_W (WORD_W),
    .NUM_P  (NUM_P),
    .IW     (IW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .clr     (zero_req),
    .we      (state == EXPAND),
    .waddr   (exp_i),
    .wdata   (wdata),
    .rev     (~enc_mode),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_skey_expand_p.sv
// tb/tb_skey_expand_p.sv - Randomized self-checking bench for skey_expand_p against a P-array reference model
module tb_skey_expand_p;

  localparam int NP   = 20;
  localparam int MAXK = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        encrypt = 1'b0;
  logic [31:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_last = 1'b0;
  logic        key_ready;
  logic        busy;
  logic        skey_ready;
  logic [4:0]  rd_idx = '0;
  logic [31:0] rd_data;
`ifdef SKEY_ZEROIZE_EN
  logic        zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  skey_expand_p #(.WORD_W(32), .NUM_P(NP), .MAX_KEY_WORDS(MAXK)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .encrypt    (encrypt),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_last   (key_last),
    .key_ready  (key_ready),
    .busy       (busy),
    .skey_ready (skey_ready),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
`ifdef SKEY_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  // pi hex-fraction words
  logic [31:0] pi_w [NP] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
  };

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] kq[$];
  int          klen;
  logic        kenc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_p(input int i);
    return pi_w[i] ^ kq[i % klen];
  endfunction

  function automatic logic [31:0] ref_rd(input int idx);
    if (idx >= NP) return 32'h0;
    return kenc ? ref_p(idx) : ref_p(NP - 1 - idx);
  endfunction

  // Streams kq with random valid gaps; returns just after the edge that
  // accepted the final word. Sets klen to the number of words accepted.
  task automatic load_key(input logic enc, input logic use_last, input string tag);
    int idx = 0;
    int guard = 0;
    bit done = 0;
    kenc = enc;
    start = 1'b1;
    encrypt = enc;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && guard < 300) begin
      guard++;
      key_valid = ($urandom_range(0, 3) != 0);
      key_in    = kq[idx];
      key_last  = use_last && (idx == kq.size() - 1);
      if (key_valid && key_ready) begin
        idx++;
        if (key_last || idx == MAXK) done = 1;
      end
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
    klen = idx;
    check({tag, "_load_done"}, 64'(done), 64'd1);
  endtask

  task automatic wait_skey(output int n, output bit saw_ready);
    n = 0;
    saw_ready = 0;
    while (n < NP + 10) begin
      @(posedge clk); #1;
      n++;
      if (key_ready) saw_ready = 1;
      if (skey_ready) break;
    end
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [31:0] exp);
    rd_idx = 5'(idx);
    @(posedge clk); #1;
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    int n;
    bit sr;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", 64'(key_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_skey_ready", 64'(skey_ready), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single zero word
    kq = '{32'h0};
    load_key(1'b1, 1'b1, "t1");
    check("t1_busy", 64'(busy), 64'd1);
    wait_skey(n, sr);
    check("t1_latency", 64'(n), 64'(NP + 1));
    read_chk("t1_p0", 0, 32'h243F6A88);
    read_chk("t1_p2", 2, 32'h13198A2E);
    check("t1_busy_done", 64'(busy), 64'd0);

    // 2: all-ones word
    kq = '{32'hFFFFFFFF};
    load_key(1'b1, 1'b1, "t2");
    wait_skey(n, sr);
    check("t2_latency", 64'(n), 64'(NP + 1));
    read_chk("t2_p0", 0, 32'hDBC09577);

    // 3: two words, with a start pulse during EXPAND that must be ignored
    kq = '{32'h01234567, 32'h89ABCDEF};
    load_key(1'b1, 1'b1, "t3");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t3_start_ignored", 64'(busy && !key_ready), 64'd1);
    wait_skey(n, sr);
    check("t3_latency", 64'(n + 1), 64'(NP + 1));
    read_chk("t3_p1", 1, 32'h0C08C53C);
    read_chk("t3_p2", 2, 32'h123ACF49);

    // 4: same key, reversed order
    load_key(1'b0, 1'b1, "t4");
    wait_skey(n, sr);
    read_chk("t4_idx0", 0, ref_p(NP - 1));
    read_chk("t4_idx19", 19, 32'h243F6A88 ^ 32'h01234567);

    // 5: 17 words, no key_last; only 16 are taken
    kq = {};
    for (int i = 0; i < 17; i++) kq.push_back($urandom);
    load_key(1'b1, 1'b0, "t5");
    check("t5_accepted", 64'(klen), 64'd16);
    check("t5_key_ready_low", 64'(key_ready), 64'd0);
    key_valid = 1'b1;
    key_in = kq[16];
    wait_skey(n, sr);
    key_valid = 1'b0;
    check("t5_no_overflow", 64'(sr), 64'd0);
    check("t5_latency", 64'(n), 64'(NP + 1));
    read_chk("t5_p16", 16, pi_w[16] ^ kq[0]);
    for (int i = 0; i < NP; i++) read_chk($sformatf("t5_p%0d", i), i, ref_rd(i));

    // 6: reset mid-EXPAND, then rerun test 1
    kq = '{32'h0};
    load_key(1'b1, 1'b1, "t6");
    repeat (7) @(posedge clk);
    #1;
    check("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_skey_ready", 64'(skey_ready), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_rd_data", 64'(rd_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    load_key(1'b1, 1'b1, "t6r");
    wait_skey(n, sr);
    check("t6_latency", 64'(n), 64'(NP + 1));
    read_chk("t6_p0", 0, 32'h243F6A88);
    read_chk("t6_p2", 2, 32'h13198A2E);

    // random keys, random mode, random indices including out-of-range
    for (int t = 0; t < 6; t++) begin
      int len = $urandom_range(1, MAXK);
      kq = {};
      for (int i = 0; i < len; i++) kq.push_back($urandom);
      load_key(1'(($urandom) & 1), 1'b1, $sformatf("r%0d", t));
      check($sformatf("r%0d_len", t), 64'(klen), 64'(len));
      wait_skey(n, sr);
      check($sformatf("r%0d_latency", t), 64'(n), 64'(NP + 1));
      for (int j = 0; j < 6; j++) begin
        int idx = $urandom_range(0, 31);
        read_chk($sformatf("r%0d_rd%0d", t, idx), idx, ref_rd(idx));
      end
      read_chk($sformatf("r%0d_oob", t), 25, 32'h0);
    end

`ifdef SKEY_ZEROIZE_EN
    // 7: zeroize in DONE
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("t7_skey_ready", 64'(skey_ready), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NP; i++) read_chk($sformatf("t7_p%0d", i), i, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/skey_expand_p.md
Name: skey_expand_p

Overview:
- Parametrised successor to the Blowfish subkey generator.
- Accepts a variable-length key as a serial word stream with a valid/ready handshake, instead of fixed parallel key ports.
- XOR-expands the key into a P-array of NUM_P words, one word per cycle, held in an internal register file.
- The cipher core reads subkeys through an indexed port; order is reversed automatically for decryption.

Parameters:
- WORD_W, 32, subkey/key word width; legal values 32 or 64.
- NUM_P, 20, P-array entries; legal range 18..20.
- MAX_KEY_WORDS, 16, key buffer depth in words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins key load. Ignored unless state is IDLE or DONE.
- encrypt  in  1  mode, sampled on start; 1 = forward order, 0 = reversed order.
- key_in  in  WORD_W  key word.
- key_valid  in  1  key word valid.
- key_last  in  1  marks the final key word.
- key_ready  out  1  block accepts a key word.
- busy  out  1  high in LOAD or EXPAND.
- skey_ready  out  1  P-array valid.
- rd_idx  in  $clog2(NUM_P)  subkey index.
- rd_data  out  WORD_W  registered subkey.

Behaviour:
- Reset values: all outputs 0; state IDLE; key count 0; P-array and key buffer cleared.
- IDLE: on start, latch encrypt, clear skey_ready, go to LOAD.
- LOAD:
  - key_ready = 1.
  - A handshake (key_valid & key_ready) writes key_buf[cnt] and increments cnt.
  - If key_last, or if the word completes MAX_KEY_WORDS: key_len = cnt+1, go to EXPAND.
  - After that transition key_ready drops. Further words are not accepted and no overflow occurs.
- EXPAND:
  - One entry per cycle, i = 0..NUM_P-1.
  - P[i] = PINIT[i] ^ key_buf[i mod key_len].
  - The modulo is implemented as a wrapping counter, not a divider.
  - After i = NUM_P-1, go to DONE.
- DONE:
  - skey_ready = 1 and holds until the next start or reset.
  - start in DONE restarts into LOAD and clears skey_ready on the following cycle.
- Latency: skey_ready rises exactly NUM_P+1 cycles after the clock edge that accepts the last key word.
- Readout:
  - rd_data is registered, 1-cycle latency.
  - Returns P[rd_idx] if the latched encrypt = 1, otherwise P[NUM_P-1-rd_idx].
  - rd_idx >= NUM_P returns 0.
  - Readout is valid only while skey_ready = 1; otherwise rd_data is don't-care, though the design returns the current contents.
- Constants:
  - For WORD_W = 32, PINIT[i] = PI[i], the pi hex-fraction words: PI[0] = 243F6A88, PI[1] = 85A308D3, PI[2] = 13198A2E, ...
  - For WORD_W = 64, PINIT[i] = {PI[2i], PI[2i+1]}.
- start during LOAD or EXPAND is ignored.
- Reset asserted mid-LOAD or mid-EXPAND returns everything to reset values immediately, asynchronously.

Optional Feature:
- Macro: SKEY_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - A pulse in any state clears the key buffer, the P-array and skey_ready, and forces IDLE on the next edge.
  - zeroize has priority over start and over key handshakes in the same cycle.
- Undefined:
  - The port is absent.
  - Contents persist until overwritten by the next expansion or by reset.

Decomposition:
- Package skey_pkg holds:
  - the PI constant table (40 words, enough for 20 entries at 64 bits);
  - the state enum (IDLE, LOAD, EXPAND, DONE);
  - a PINIT lookup function taking WORD_W and the index.
- One sub-module: skey_regfile.
  - NUM_P x WORD_W storage with one write port and one registered read port.
  - Includes the reverse-index mapping.

Test Plan:
1. Single key word 00000000 with key_last, encrypt = 1 -> skey_ready at +21 cycles; rd_idx 0 -> 243F6A88; rd_idx 2 -> 13198A2E.
2. Single key word FFFFFFFF -> rd_idx 0 -> DBC09577.
3. Two words 01234567, 89ABCDEF -> P[1] = 0C08C53C, P[2] = 123ACF49.
4. Same key with encrypt = 0 -> rd_idx 0 returns P[19]; rd_idx 19 returns P[0] = 243F6A88 ^ 01234567.
5. 17 words, key_last never asserted -> only 16 handshakes occur; key_ready drops after the 16th; P[16] uses key_buf[0].
6. rst asserted at EXPAND step 7 -> skey_ready = 0, busy = 0 immediately; restart with key 00000000 -> test 1 values.
7. (SKEY_ZEROIZE_EN defined) zeroize in DONE -> skey_ready = 0 next cycle; all P entries read 0.
